// File: rtl/jtframe_romrq_arb.sv
// Round-robin arbiter: up to four ROM request slots share one SDRAM read port.
// Each grant is a 2-word burst returned through a registered data path; stalled bursts time out.
module jtframe_romrq_arb #(
    parameter int SLOTS  = 4,
    parameter int SDRAMW = 22,
    parameter int TOUT   = 63
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SLOTS-1:0]         slot_req,
    input  logic [SLOTS*SDRAMW-1:0]  slot_addr,
    output logic [SLOTS-1:0]         slot_we,
    output logic                     slot_dst,
    output logic                     slot_din_ok,
    output logic [15:0]              slot_din,
    output logic                     sdram_req,
    output logic [SDRAMW-1:0]        sdram_addr,
    input  logic                     sdram_ack,
    input  logic                     sdram_dok,
    input  logic [15:0]              sdram_din,
    output logic                     err
);
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int TW = $clog2(TOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, W0, W1, END} state_t;

    state_t              state_reg, state_next;
    logic [IW-1:0]       last_reg, last_next;
    logic [IW-1:0]       grant_reg, grant_next;
    logic [TW-1:0]       timer_reg, timer_next;
    logic [TW-1:0]       tinc;
    logic                timeout, abort;

    logic [SLOTS-1:0]    we_next;
    logic                req_next, dst_next, din_ok_next, err_next;
    logic [SDRAMW-1:0]   addr_next;
    logic [15:0]         din_next;

    logic [SDRAMW-1:0]   addr_arr [SLOTS];
    logic                found;
    logic [IW-1:0]       win;
    int                  cand;

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_addr
        assign addr_arr[gi] = slot_addr[gi*SDRAMW +: SDRAMW];
    end

    // Search begins one past the last completed grant so every slot gets its turn.
    always_comb begin
        cand  = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= SLOTS; k++) begin
            cand = (int'(last_reg) + k) % SLOTS;
            if (!found && slot_req[IW'(cand)]) begin
                found = 1'b1;
                win   = IW'(cand);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        last_next   = last_reg;
        grant_next  = grant_reg;
        timer_next  = timer_reg;
        we_next     = slot_we;
        req_next    = sdram_req;
        addr_next   = sdram_addr;
        din_next    = slot_din;
        dst_next    = 1'b0;
        din_ok_next = 1'b0;
        err_next    = 1'b0;
        abort       = 1'b0;
        tinc        = timer_reg + 1'b1;
        timeout     = (tinc == TW'(TOUT));

        case (state_reg)
            IDLE: begin
                if (found) begin
                    grant_next = win;
                    addr_next  = addr_arr[win];
                    we_next    = SLOTS'(1) << win;
                    req_next   = 1'b1;
                    timer_next = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                timer_next = tinc;
                if (timeout) begin
                    abort = 1'b1;
                end else if (sdram_ack) begin
                    req_next = 1'b0;
                    if (sdram_dok) begin
                        din_next   = sdram_din;
                        dst_next   = 1'b1;
                        state_next = W1;
                    end else begin
                        state_next = W0;
                    end
                end
            end
            W0: begin
                timer_next = tinc;
                if (timeout) begin
                    abort = 1'b1;
                end else if (sdram_dok) begin
                    din_next   = sdram_din;
                    dst_next   = 1'b1;
                    state_next = W1;
                end
            end
            W1: begin
                timer_next = tinc;
                // A last word arriving on the timeout cycle still completes the burst.
                if (sdram_dok) begin
                    din_next    = sdram_din;
                    din_ok_next = 1'b1;
                    state_next  = END;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            END: begin
                we_next    = '0;
                last_next  = grant_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Aborted bursts leave the pointer alone so the same slot is first in line again.
        if (abort) begin
            we_next    = '0;
            req_next   = 1'b0;
            err_next   = 1'b1;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            last_reg    <= IW'(SLOTS - 1);
            grant_reg   <= '0;
            timer_reg   <= '0;
            slot_we     <= '0;
            sdram_req   <= 1'b0;
            sdram_addr  <= '0;
            slot_din    <= '0;
            slot_dst    <= 1'b0;
            slot_din_ok <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_reg   <= state_next;
            last_reg    <= last_next;
            grant_reg   <= grant_next;
            timer_reg   <= timer_next;
            slot_we     <= we_next;
            sdram_req   <= req_next;
            sdram_addr  <= addr_next;
            slot_din    <= din_next;
            slot_dst    <= dst_next;
            slot_din_ok <= din_ok_next;
            err         <= err_next;
        end
    end
endmodule

// File: doc/jtframe_romrq_arb.md
# jtframe_romrq_arb

Round-robin arbiter between up to four ROM request slots and one SDRAM read port. Each slot sees the shared read-data bus plus a private grant strobe, and the slots' per-slot caches absorb the returned data. The block latches the winning slot's address, issues a 2-word burst read to the SDRAM controller and streams the two words back as a one-cycle-delayed, registered response. A timeout aborts stalled bursts so the slot can re-request.

## Interface
- SLOTS, 4: number of request slots, legal range 2..4
- SDRAMW, 22: SDRAM word-address width
- TOUT, 63: cycles allowed from grant to second data word before abort; counter width is clog2(TOUT+1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- slot_req  in  SLOTS  per-slot request level
- slot_addr  in  SLOTS*SDRAMW  per-slot word address; slot i at bits [i*SDRAMW +: SDRAMW]
- slot_we  out  SLOTS  one-hot grant, high while the slot owns the port
- slot_dst  out  1  first data word on slot_din
- slot_din_ok  out  1  second (last) data word on slot_din
- slot_din  out  16  shared registered read data
- sdram_req  out  1  read request to SDRAM controller
- sdram_addr  out  SDRAMW  latched address of granted slot
- sdram_ack  in  1  one-cycle strobe: request accepted
- sdram_dok  in  1  one-cycle strobe: sdram_din holds a valid word
- sdram_din  in  16  SDRAM read data
- err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, REQ, W0, W1, END.
- IDLE: if any slot_req is high, pick the winner round-robin. Search starts at the slot after the last granted one, wrapping at SLOTS-1 to 0.
  - Register the winner's address into sdram_addr.
  - Set slot_we one-hot and sdram_req=1, clear the timer, go to REQ.
- REQ: hold sdram_req and sdram_addr until sdram_ack. On ack, sdram_req drops next cycle and the state goes to W0. If sdram_dok arrives in the same cycle as sdram_ack, it is taken as word 0 and the state goes to W1.
- W0: the first sdram_dok captures word 0 and the state goes to W1.
- W1: the next sdram_dok captures word 1 and the state goes to END.
- END: slot_we clears, the last-grant pointer updates, the state returns to IDLE.
- Slot_req is sampled only in IDLE. A slot that drops its request after grant still receives the full burst, because the SDRAM is already committed.
- Timer counts every cycle outside IDLE/END. Reaching TOUT in REQ, W0 or W1 aborts the burst:
  - sdram_req=0 and slot_we=0 next cycle, err pulses one cycle, return to IDLE.
  - No slot_din_ok is issued; the slot re-requests naturally.
- Stray sdram_dok in IDLE/END is ignored.

## Timing
- Reset values: slot_we=0, slot_dst=0, slot_din_ok=0, slot_din=0, sdram_req=0, sdram_addr=0, err=0, state IDLE, last-grant pointer = SLOTS-1 (so slot 0 wins first).
- Grant latency: slot_req high in IDLE gives slot_we and sdram_req high on the next edge.
- Data path is registered with one cycle of latency:
  - Word 0: sdram_dok at edge n gives slot_dst=1 and slot_din=word0 during cycle n+1.
  - Word 1: same rule, with slot_din_ok=1 and slot_din=word1.
- slot_dst and slot_din_ok are never high in the same cycle, and each lasts exactly one cycle.
- slot_we stays high through the cycle in which slot_din_ok is high and falls on the following edge, which is the END→IDLE edge.
- Earliest back-to-back grant is the cycle after slot_we falls. From IDLE sampling to the next possible grant is 1 cycle, so each burst costs at least 2 idle-edge cycles of overhead.
- Simultaneous requests: exactly one grant; the others wait in priority order.
- Async reset mid-burst: all outputs clear immediately, and later ack/dok strobes are ignored until a new grant.

## Test plan
- Single slot: slot 1 requests address 0x12345, ack after 3 cycles, dok with 0xAAAA then 0x5555.
  - Required: sdram_addr=0x12345.
  - slot_dst with 0xAAAA, then slot_din_ok with 0x5555 one cycle after each dok.
  - slot_we=0010 through the cycle of slot_din_ok.
- Fairness: all 4 slots request continuously for 8 bursts. Grant order must be 0,1,2,3,0,1,2,3 and no slot_we overlap.
- Ack and dok in the same cycle, then dok on the next cycle. Required: slot_dst and slot_din_ok on consecutive cycles with correct data.
- Timeout, TOUT=63: ack arrives but no dok follows.
  - Required: err pulse 63 cycles after grant, slot_we=0, no slot_din_ok.
  - Slot re-requests and is granted again.
- Request withdrawn after grant: slot_req drops in REQ. The burst still completes with slot_dst and slot_din_ok.
- Reset mid-burst: rst_n low while in W1. All outputs are 0 immediately; a subsequent dok produces no slot_din_ok.
